// File: rtl/conv_expand_engine.sv
// conv_expand_engine
// Output-stationary convolution engine for fire squeeze/expand layers.
// DSP_NO parallel MACs accumulate one output pixel across all taps:
// TAPS = KERNEL_DIM*KERNEL_DIM*CHIN.
//
// Each output pixel is finished in four steps:
//   1. add the bias,
//   2. rescale by FRAC with an arithmetic shift,
//   3. saturate to signed WIDTH,
//   4. register all channels for the downstream RAM writer.
//
// Optional feature: define RELU_EN to clamp negative results to zero after
// saturation.
//
// Ports:
//   clk           rising-edge clock
//   rst           synchronous, active-low reset
//   layer_en      level; the layer runs while high and stalls while low
//   ifm           input pixel (signed fixed point)
//   ifm_valid     ifm holds a pixel
//   ifm_ready     engine takes ifm this cycle
//   weight_addr   tap index to the external weight ROM
//   weight_data   weight vector; channel i is at [i*WIDTH+:WIDTH]
//   bias_data     per-channel bias, already scaled by 2**FRAC
//   ofm           registered output channels
//   ofm_sample    1-cycle pulse; ofm holds a new pixel
//   ram_feedback  downstream acknowledge of layer end; latched
//   layer_finish  layer done and no acknowledge seen yet
//   state_o       FSM state, for observation
//
// Handshake: an ifm beat transfers on a rising edge where ifm_valid and
// ifm_ready are both high. ifm_ready does not depend on ifm_valid.
// ofm has no backpressure.
module conv_expand_engine #(
  parameter int WIDTH      = 16,
  parameter int FRAC       = 14,
  parameter int DSP_NO     = 256,
  parameter int CHIN       = 64,
  parameter int KERNEL_DIM = 3,
  parameter int WOUT       = 16,
  localparam int TAPS      = KERNEL_DIM * KERNEL_DIM * CHIN,
  localparam int NPIX      = WOUT * WOUT,
  localparam int AW        = (TAPS > 1) ? $clog2(TAPS) : 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        layer_en,
  input  logic [WIDTH-1:0]            ifm,
  input  logic                        ifm_valid,
  output logic                        ifm_ready,
  output logic [AW-1:0]               weight_addr,
  input  logic [DSP_NO*WIDTH-1:0]     weight_data,
  input  logic [DSP_NO*2*WIDTH-1:0]   bias_data,
  output logic [DSP_NO*WIDTH-1:0]     ofm,
  output logic                        ofm_sample,
  input  logic                        ram_feedback,
  output logic                        layer_finish,
  output logic [2:0]                  state_o
);

  localparam int ACC_W = 2 * WIDTH + $clog2(TAPS);
  localparam int PW    = $clog2(NPIX + 1);
  localparam logic signed [ACC_W:0] SAT_MAX = {{(ACC_W-WIDTH+2){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [ACC_W:0] SAT_MIN = {{(ACC_W-WIDTH+2){1'b1}}, {(WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {S_IDLE, S_ACCUM, S_DRAIN, S_OUT, S_DONE} state_t;

  state_t                  state_q, state_d;
  logic [AW-1:0]           tap_q, tap_d;
  logic [PW-1:0]           pix_cnt_q, pix_cnt_d;
  logic signed [WIDTH-1:0] pix_q;
  logic                    mac_q;    // a MAC is due this cycle (weight_data now valid)
  logic                    first_q;  // that MAC is tap 0: load instead of add
  logic signed [ACC_W-1:0] acc_q [DSP_NO];
  logic signed [2*WIDTH-1:0] prod [DSP_NO];
  logic signed [ACC_W-1:0] prod_ext [DSP_NO];
  logic [DSP_NO*WIDTH-1:0] ofm_q, ofm_d;
  logic                    ofm_sample_q;
  logic                    fb_q;
  logic                    accept;

  assign ifm_ready    = (state_q == S_ACCUM) && layer_en;
  assign accept       = ifm_valid && ifm_ready;
  assign weight_addr  = tap_q;
  assign ofm          = ofm_q;
  assign ofm_sample   = ofm_sample_q;
  assign layer_finish = (state_q == S_DONE) && !fb_q;
  assign state_o      = state_q;

  // Add the bias, rescale, saturate to signed WIDTH, then optionally apply ReLU.
  // One extra bit of headroom keeps acc + bias from wrapping.
  function automatic logic [WIDTH-1:0] scale_sat(input logic signed [ACC_W-1:0] a,
                                                 input logic [2*WIDTH-1:0] b);
    logic signed [ACC_W:0] s;
    s = {a[ACC_W-1], a} + {{(ACC_W+1-2*WIDTH){b[2*WIDTH-1]}}, b};
    s = s >>> FRAC;
    if (s > SAT_MAX) s = SAT_MAX;
    else if (s < SAT_MIN) s = SAT_MIN;
`ifdef RELU_EN
    if (s < 0) s = '0;
`endif
    return s[WIDTH-1:0];
  endfunction

  always_comb begin
    state_d   = state_q;
    tap_d     = tap_q;
    pix_cnt_d = pix_cnt_q;
    case (state_q)
      S_IDLE:  if (layer_en) state_d = S_ACCUM;
      S_ACCUM: begin
        if (accept) begin
          if (tap_q == AW'(TAPS - 1)) begin
            tap_d   = '0;
            state_d = S_DRAIN;
          end else begin
            tap_d = tap_q + AW'(1);
          end
        end
      end
      S_DRAIN: state_d = S_OUT;
      S_OUT: begin
        pix_cnt_d = pix_cnt_q + PW'(1);
        state_d   = (pix_cnt_q == PW'(NPIX - 1)) ? S_DONE : S_ACCUM;
      end
      S_DONE:  state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ofm_d = '0;
    for (int i = 0; i < DSP_NO; i++) begin
      prod[i]     = pix_q * $signed(weight_data[i*WIDTH +: WIDTH]);
      prod_ext[i] = {{(ACC_W-2*WIDTH){prod[i][2*WIDTH-1]}}, prod[i]};
      ofm_d[i*WIDTH +: WIDTH] = scale_sat(acc_q[i], bias_data[i*2*WIDTH +: 2*WIDTH]);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      tap_q        <= '0;
      pix_cnt_q    <= '0;
      pix_q        <= '0;
      mac_q        <= 1'b0;
      first_q      <= 1'b0;
      ofm_q        <= '0;
      ofm_sample_q <= 1'b0;
      fb_q         <= 1'b0;
      for (int i = 0; i < DSP_NO; i++) acc_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      tap_q     <= tap_d;
      pix_cnt_q <= pix_cnt_d;
      mac_q     <= accept;
      if (accept) begin
        pix_q   <= ifm;
        first_q <= (tap_q == '0);
      end
      if (mac_q) begin
        for (int i = 0; i < DSP_NO; i++)
          acc_q[i] <= first_q ? prod_ext[i] : acc_q[i] + prod_ext[i];
      end
      if (state_q == S_OUT) ofm_q <= ofm_d;
      ofm_sample_q <= (state_q == S_OUT);
      fb_q         <= fb_q | ram_feedback;
    end
  end

endmodule
